sdc_alu_pipe: RTL and testbench
===============================

Name: sdc_alu_pipe

Overview:
Parametrised, two-stage pipelined successor to the single-cycle DSP-core ALU. It adds a valid/ready handshake, a registered flag set, carry-chained add/subtract, shifts, optional signed saturation and a signed multiply-accumulate unit with a wide accumulator. It sits between the operand-fetch/decode logic and writeback in the SDC DSP core.

Parameters:
BIT_WIDTH, 32, operand/result width (>= 8)
ACC_GUARD, 8, accumulator guard bits; ACC_WIDTH = 2*BIT_WIDTH + ACC_GUARD (localparam)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
alu_in_valid  in  1  operation offered
alu_in_ready  out  1  operation accepted when valid & ready
alu_in1  in  BIT_WIDTH  operand A
alu_in2  in  BIT_WIDTH  operand B / shift amount
alu_fcn  in  5  opcode
alu_sat  in  1  saturate ADD/SUB/ADC/SBC/ACCRD (signed)
alu_out_valid  out  1  result valid
alu_out_ready  in  1  downstream accepts result
alu_out  out  BIT_WIDTH  result
alu_cr  out  1  carry (add) / borrow (sub)
alu_zero  out  1  alu_out == 0
alu_neg  out  1  alu_out MSB
alu_ovf  out  1  signed overflow (before saturation)
alu_err  out  1  illegal opcode

Behaviour:
- Clock is clk; reset is synchronous, active-high rst. Reset clears S1/S2 valid, alu_out, all flags and the accumulator to 0. In-flight ops are discarded. alu_in_ready = 1 in the cycle after reset.
- Pipeline: S1 registers operands/fcn/sat. Execution is combinational between S1 and S2. S2 holds result and flags, which drive the outputs directly.
- Latency: 2 cycles from accept to alu_out_valid. Throughput: 1 op/cycle.
- Stall = alu_out_valid & !alu_out_ready. On stall, both stages hold and alu_in_ready = 0 (combinational). Otherwise all stages advance. Outputs stay stable while stalled. Order is preserved.
- Flags are written only when an op enters S2. ADC/SBC read alu_cr from S2, which always holds the immediately preceding op's carry, so there is no hazard.
- Opcodes (all others: alu_err=1, alu_out=0, other flags 0, accumulator unchanged):
  00000 NOT ~A
  00001 OR
  00010 AND
  00011 XOR
  00100 ADD A+B, cr=carry-out
  00101 SUB A-B, cr=borrow (A<B unsigned)
  00110 ADC A+B+cr
  00111 SBC A-B-cr
  01000 SHL A<<B
  01001 SHR logical
  01010 SAR arithmetic
  01011 MUL signed, low BIT_WIDTH of A*B
  01100 MAC acc += signed A*B, out = truncated acc
  01101 ACCCLR acc=0, out=0
  01110 ACCRD out = acc (saturated if alu_sat, else truncated)
- Logic ops, shifts and MUL: cr=0, ovf=0. MAC/ACCRD: ovf=1 if acc is out of signed BIT_WIDTH range.
- Shift amount B >= BIT_WIDTH: SHL/SHR give 0; SAR gives all sign bits. Shifts set cr=0.
- Saturation (alu_sat=1, arithmetic ops): on signed overflow, out = 0x7F..F if positive, 0x80..0 if negative. ovf=1 regardless of alu_sat. cr is unaffected by saturation.
- Accumulator wraps modulo 2^ACC_WIDTH. It updates only when the MAC/ACCCLR op advances into S2, and never while stalled.
- zero and neg always reflect the final (post-saturation) alu_out.

Decomposition:
- Package sdc_alu_pkg: alu_fcn_e enum with the opcodes above, ALU_FCN_W=5, and helper functions sat_signed() and is_legal_fcn().
- Sub-module sdc_alu_mac: signed multiplier, accumulator register, clear/read/saturate. Parameters BIT_WIDTH and ACC_GUARD. Enable is driven by the pipeline advance.

Test Plan:
- ADD 0xFFFFFFFF+0x00000001, then ADC 0+0 -> first result 0, cr=1, zero=1; second result 0x00000001, cr=0.
- ADD 0x7FFFFFFF+1 with alu_sat=0 -> 0x80000000, ovf=1, neg=1. With alu_sat=1 -> 0x7FFFFFFF, ovf=1, neg=0.
- ACCCLR, MAC(3,-4), MAC(5,5), ACCRD -> MAC outputs 0xFFFFFFF4 then 0x0000000D; ACCRD 0x0000000D; illegal fcn 5'b11111 mid-sequence -> err=1, out=0, later ACCRD still 13.
- Issue 4 back-to-back ops with alu_out_ready=0 for 3 cycles -> alu_in_ready falls once S2 and S1 are full; outputs held stable; all 4 results emerge in order, none lost or duplicated.
- SAR 0x80000000 by 40 -> 0xFFFFFFFF; SHR same -> 0; SHL 0x1 by 31 -> 0x80000000, neg=1.
- Assert rst during a stalled, full pipeline -> next cycle alu_out_valid=0, all flags 0, accumulator 0; a subsequent ACCRD returns 0.

Source files
------------

// File: rtl/sdc_alu_pkg.sv
// Shared opcode encoding and helpers for the SDC pipelined ALU.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sdc_alu_pkg;

    localparam int ALU_FCN_W = 5;
    // Widest datapath the saturation helper can build a pattern for.
    localparam int SAT_MAX_W = 256;

    typedef enum logic [ALU_FCN_W-1:0] {
        FCN_NOT    = 5'b00000,
        FCN_OR     = 5'b00001,
        FCN_AND    = 5'b00010,
        FCN_XOR    = 5'b00011,
        FCN_ADD    = 5'b00100,
        FCN_SUB    = 5'b00101,
        FCN_ADC    = 5'b00110,
        FCN_SBC    = 5'b00111,
        FCN_SHL    = 5'b01000,
        FCN_SHR    = 5'b01001,
        FCN_SAR    = 5'b01010,
        FCN_MUL    = 5'b01011,
        FCN_MAC    = 5'b01100,
        FCN_ACCCLR = 5'b01101,
        FCN_ACCRD  = 5'b01110
    } alu_fcn_e;

    // Signed clamp value for a 'width'-bit result: 0x80..0 when the true
    // value is negative, 0x7F..F otherwise. Callers cast to their width.
    function automatic logic [SAT_MAX_W-1:0] sat_signed(input logic neg, input int unsigned width);
        logic [SAT_MAX_W-1:0] msb;
        msb = SAT_MAX_W'(1) << (width - 1);
        return neg ? msb : (msb - SAT_MAX_W'(1));
    endfunction

    function automatic logic is_legal_fcn(input logic [ALU_FCN_W-1:0] fcn);
        return fcn <= FCN_ACCRD;
    endfunction

endpackage

// File: rtl/sdc_alu_mac.sv
// Signed multiplier plus wide accumulator (clear / accumulate / read with optional saturation).
// Latency: results combinational from operands and current accumulator; accumulator updates on clk.
// Backpressure: none internally; the caller gates i_mac_en/i_clr_en with its pipeline advance.
// Ports: i_a/i_b operands, i_sat saturate read, o_mul_dat low product, o_mac_* accumulate result,
//        o_rd_* accumulator read.
module sdc_alu_mac
    import sdc_alu_pkg::*;
#(
    parameter int BIT_WIDTH = 32,
    parameter int ACC_GUARD = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_mac_en,
    input  logic                 i_clr_en,
    input  logic                 i_sat,
    input  logic [BIT_WIDTH-1:0] i_a,
    input  logic [BIT_WIDTH-1:0] i_b,
    output logic [BIT_WIDTH-1:0] o_mul_dat,
    output logic [BIT_WIDTH-1:0] o_mac_dat,
    output logic                 o_mac_ovf,
    output logic [BIT_WIDTH-1:0] o_rd_dat,
    output logic                 o_rd_ovf
);

    localparam int ACC_WIDTH = 2 * BIT_WIDTH + ACC_GUARD;
    localparam int PROD_W    = 2 * BIT_WIDTH;

    logic signed [PROD_W-1:0] w_prod;
    logic [ACC_WIDTH-1:0]     w_acc_sum;
    logic [ACC_WIDTH-1:0]     r_acc;

    // A wide value fits the signed result range when every bit from the
    // result MSB upward is a copy of the sign.
    function automatic logic fits_w(input logic [ACC_WIDTH-BIT_WIDTH:0] hi);
        return (&hi) | ~(|hi);
    endfunction

    assign w_prod    = $signed(i_a) * $signed(i_b);
    assign w_acc_sum = r_acc + {{ACC_GUARD{w_prod[PROD_W-1]}}, w_prod};

    assign o_mul_dat = w_prod[BIT_WIDTH-1:0];
    assign o_mac_dat = w_acc_sum[BIT_WIDTH-1:0];
    assign o_mac_ovf = ~fits_w(w_acc_sum[ACC_WIDTH-1:BIT_WIDTH-1]);
    assign o_rd_ovf  = ~fits_w(r_acc[ACC_WIDTH-1:BIT_WIDTH-1]);
    assign o_rd_dat  = (i_sat && o_rd_ovf) ? BIT_WIDTH'(sat_signed(r_acc[ACC_WIDTH-1], BIT_WIDTH))
                                           : r_acc[BIT_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_clr_en) begin
            r_acc <= '0;
        end else if (i_mac_en) begin
            r_acc <= w_acc_sum;
        end
    end

endmodule

// File: rtl/sdc_alu_pipe.sv
// Two-stage pipelined DSP ALU: logic, carry-chained add/sub, shifts, saturation, signed MAC.
// Latency: 2 cycles accept -> alu_out_valid; 1 op/cycle throughput.
// Backpressure: alu_out_valid & !alu_out_ready freezes both stages and drops alu_in_ready combinationally.
// Ports: alu_in_* request side (valid/ready, operands, opcode, sat), alu_out_* result side with flags
//        alu_cr/zero/neg/ovf/err held in the output stage.
module sdc_alu_pipe
    import sdc_alu_pkg::*;
#(
    parameter int BIT_WIDTH = 32,
    parameter int ACC_GUARD = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_in_valid,
    output logic                 alu_in_ready,
    input  logic [BIT_WIDTH-1:0] alu_in1,
    input  logic [BIT_WIDTH-1:0] alu_in2,
    input  logic [ALU_FCN_W-1:0] alu_fcn,
    input  logic                 alu_sat,
    output logic                 alu_out_valid,
    input  logic                 alu_out_ready,
    output logic [BIT_WIDTH-1:0] alu_out,
    output logic                 alu_cr,
    output logic                 alu_zero,
    output logic                 alu_neg,
    output logic                 alu_ovf,
    output logic                 alu_err
);

    localparam int W = BIT_WIDTH;
    localparam logic [W-1:0] SH_LIM = W'(W);

    // Stage 1: registered request
    logic                 r_s1_vld;
    logic [W-1:0]         r_s1_a;
    logic [W-1:0]         r_s1_b;
    logic [ALU_FCN_W-1:0] r_s1_fcn;
    logic                 r_s1_sat;

    // Stage 2: result and flags, driving the outputs directly
    logic         r_s2_vld;
    logic [W-1:0] r_out;
    logic         r_cr, r_zero, r_neg, r_ovf, r_err;

    logic         w_adv, w_s2_load;
    logic         w_cin, w_sh_big;
    logic [W+1:0] w_s_sum, w_s_diff;
    logic [W-1:0] w_res, w_mul_dat, w_mac_dat, w_rd_dat;
    logic         w_mac_ovf, w_rd_ovf;
    logic         w_cr, w_zero, w_neg, w_ovf, w_err;

    function automatic logic fits_w(input logic [2:0] top3);
        return (&top3) | ~(|top3);
    endfunction

    assign w_adv        = ~(r_s2_vld & ~alu_out_ready);
    assign w_s2_load    = w_adv & r_s1_vld;
    assign alu_in_ready = w_adv;

    assign alu_out_valid = r_s2_vld;
    assign alu_out       = r_out;
    assign alu_cr        = r_cr;
    assign alu_zero      = r_zero;
    assign alu_neg       = r_neg;
    assign alu_ovf       = r_ovf;
    assign alu_err       = r_err;

    // r_cr is the carry of the op now in S2, i.e. the op just ahead of the
    // one in S1, so ADC/SBC chain without any forwarding.
    assign w_cin = ((r_s1_fcn == FCN_ADC) || (r_s1_fcn == FCN_SBC)) ? r_cr : 1'b0;

    // Two guard bits: the sum/difference plus carry-in cannot overflow W+2 bits.
    assign w_s_sum  = {{2{r_s1_a[W-1]}}, r_s1_a} + {{2{r_s1_b[W-1]}}, r_s1_b} + {{(W+1){1'b0}}, w_cin};
    assign w_s_diff = {{2{r_s1_a[W-1]}}, r_s1_a} - {{2{r_s1_b[W-1]}}, r_s1_b} - {{(W+1){1'b0}}, w_cin};
    assign w_sh_big = (r_s1_b >= SH_LIM);

    sdc_alu_mac #(
        .BIT_WIDTH (BIT_WIDTH),
        .ACC_GUARD (ACC_GUARD)
    ) u_mac (
        .clk       (clk),
        .rst       (rst),
        .i_mac_en  (w_s2_load && (r_s1_fcn == FCN_MAC)),
        .i_clr_en  (w_s2_load && (r_s1_fcn == FCN_ACCCLR)),
        .i_sat     (r_s1_sat),
        .i_a       (r_s1_a),
        .i_b       (r_s1_b),
        .o_mul_dat (w_mul_dat),
        .o_mac_dat (w_mac_dat),
        .o_mac_ovf (w_mac_ovf),
        .o_rd_dat  (w_rd_dat),
        .o_rd_ovf  (w_rd_ovf)
    );

    always_comb begin
        w_res = '0;
        w_cr  = 1'b0;
        w_ovf = 1'b0;
        w_err = ~is_legal_fcn(r_s1_fcn);
        case (r_s1_fcn)
            FCN_NOT: w_res = ~r_s1_a;
            FCN_OR:  w_res = r_s1_a | r_s1_b;
            FCN_AND: w_res = r_s1_a & r_s1_b;
            FCN_XOR: w_res = r_s1_a ^ r_s1_b;
            FCN_ADD, FCN_ADC: begin
                w_res = w_s_sum[W-1:0];
                // Unsigned carry-out recovered from the sign-extended sum bit W.
                w_cr  = w_s_sum[W] ^ r_s1_a[W-1] ^ r_s1_b[W-1];
                w_ovf = ~fits_w(w_s_sum[W+1:W-1]);
                if (r_s1_sat && w_ovf) w_res = W'(sat_signed(w_s_sum[W+1], W));
            end
            FCN_SUB, FCN_SBC: begin
                w_res = w_s_diff[W-1:0];
                // Same trick yields the unsigned borrow.
                w_cr  = w_s_diff[W] ^ r_s1_a[W-1] ^ r_s1_b[W-1];
                w_ovf = ~fits_w(w_s_diff[W+1:W-1]);
                if (r_s1_sat && w_ovf) w_res = W'(sat_signed(w_s_diff[W+1], W));
            end
            FCN_SHL: w_res = w_sh_big ? '0 : (r_s1_a << r_s1_b);
            FCN_SHR: w_res = w_sh_big ? '0 : (r_s1_a >> r_s1_b);
            FCN_SAR: w_res = w_sh_big ? {W{r_s1_a[W-1]}} : W'($signed(r_s1_a) >>> r_s1_b);
            FCN_MUL: w_res = w_mul_dat;
            FCN_MAC: begin
                w_res = w_mac_dat;
                w_ovf = w_mac_ovf;
            end
            FCN_ACCCLR: w_res = '0;
            FCN_ACCRD: begin
                w_res = w_rd_dat;
                w_ovf = w_rd_ovf;
            end
            default: ;
        endcase
        // Illegal ops report only err; zero is suppressed even though out is 0.
        w_zero = ~w_err & (w_res == '0);
        w_neg  = w_res[W-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld <= 1'b0;
            r_s1_a   <= '0;
            r_s1_b   <= '0;
            r_s1_fcn <= '0;
            r_s1_sat <= 1'b0;
        end else if (w_adv) begin
            r_s1_vld <= alu_in_valid;
            r_s1_a   <= alu_in1;
            r_s1_b   <= alu_in2;
            r_s1_fcn <= alu_fcn;
            r_s1_sat <= alu_sat;
        end
    end

    // Flags only change when a real op enters S2; bubbles keep the old carry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_vld <= 1'b0;
            r_out    <= '0;
            r_cr     <= 1'b0;
            r_zero   <= 1'b0;
            r_neg    <= 1'b0;
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
        end else if (w_adv) begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_out  <= w_res;
                r_cr   <= w_cr;
                r_zero <= w_zero;
                r_neg  <= w_neg;
                r_ovf  <= w_ovf;
                r_err  <= w_err;
            end
        end
    end

endmodule

// File: tb/tb_sdc_alu_pipe.sv
// Testbench for sdc_alu_pipe: directed cases plus randomized ops against an arithmetic reference model.
// Latency: n/a.
// Backpressure: alu_out_ready is driven directed or randomized.
module tb_sdc_alu_pipe;

    typedef struct packed {
        logic [31:0] out;
        logic [4:0]  flags;   // {cr, zero, neg, ovf, err}
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_in_valid;
    logic        alu_in_ready;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [4:0]  alu_fcn;
    logic        alu_sat;
    logic        alu_out_valid;
    logic        alu_out_ready;
    logic [31:0] alu_out;
    logic        alu_cr, alu_zero, alu_neg, alu_ovf, alu_err;
    logic [4:0]  w_flags;

    int n_tests = 0;
    int n_fail  = 0;

    logic rdy_force = 1'b1;
    logic rdy_val   = 1'b1;

    res_t exp_q[$];
    res_t got_q[$];

    logic               m_cr;
    logic signed [71:0] m_acc;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    assign w_flags = {alu_cr, alu_zero, alu_neg, alu_ovf, alu_err};

    sdc_alu_pipe dut (
        .clk           (clk),
        .rst           (rst),
        .alu_in_valid  (alu_in_valid),
        .alu_in_ready  (alu_in_ready),
        .alu_in1       (alu_in1),
        .alu_in2       (alu_in2),
        .alu_fcn       (alu_fcn),
        .alu_sat       (alu_sat),
        .alu_out_valid (alu_out_valid),
        .alu_out_ready (alu_out_ready),
        .alu_out       (alu_out),
        .alu_cr        (alu_cr),
        .alu_zero      (alu_zero),
        .alu_neg       (alu_neg),
        .alu_ovf       (alu_ovf),
        .alu_err       (alu_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: evaluates each op in acceptance order with plain integer arithmetic.
    task automatic model_op(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                            input logic s, output res_t r);
        longint      as_, bs_, au, bu, c, sum, p;
        logic [63:0] t;
        logic [31:0] o;
        logic        cr, ovf, err;
        as_ = $signed(a);
        bs_ = $signed(b);
        au  = {32'd0, a};
        bu  = {32'd0, b};
        c   = {63'd0, m_cr};
        p   = as_ * bs_;
        o = '0; cr = 1'b0; ovf = 1'b0; err = 1'b0;
        case (f)
            5'd0: o = ~a;
            5'd1: o = a | b;
            5'd2: o = a & b;
            5'd3: o = a ^ b;
            5'd4, 5'd6: begin
                if (f == 5'd4) c = 0;
                sum = as_ + bs_ + c;
                cr  = (au + bu + c) > 64'sd4294967295;
                ovf = (sum > MAXV) || (sum < MINV);
                t   = sum;
                o   = t[31:0];
                if (s && ovf) o = (sum < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end
            5'd5, 5'd7: begin
                if (f == 5'd5) c = 0;
                sum = as_ - bs_ - c;
                cr  = au < (bu + c);
                ovf = (sum > MAXV) || (sum < MINV);
                t   = sum;
                o   = t[31:0];
                if (s && ovf) o = (sum < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end
            5'd8: begin t = au << bu; o = (bu >= 32) ? 32'd0 : t[31:0]; end
            5'd9: begin t = au >> bu; o = (bu >= 32) ? 32'd0 : t[31:0]; end
            5'd10: begin t = as_ >>> ((bu > 31) ? 31 : bu); o = t[31:0]; end
            5'd11: begin t = p; o = t[31:0]; end
            5'd12: begin
                m_acc = m_acc + p;
                o     = m_acc[31:0];
                ovf   = (m_acc > MAXV) || (m_acc < MINV);
            end
            5'd13: m_acc = '0;
            5'd14: begin
                ovf = (m_acc > MAXV) || (m_acc < MINV);
                o   = (s && ovf) ? ((m_acc < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF) : m_acc[31:0];
            end
            default: err = 1'b1;
        endcase
        m_cr    = cr;
        r.out   = o;
        r.flags = {cr, (!err && (o == 32'd0)), o[31], ovf, err};
    endtask

    // Monitor: samples mid-cycle, checks every valid output against the model's head entry.
    initial begin
        res_t r;
        m_cr  = 1'b0;
        m_acc = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                m_cr  = 1'b0;
                m_acc = '0;
            end else begin
                if (alu_out_valid) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_out", 64'd1, 64'd0);
                    end else begin
                        check("out", 64'(alu_out), 64'(exp_q[0].out));
                        check("flags", 64'(w_flags), 64'(exp_q[0].flags));
                        if (alu_out_ready) begin
                            got_q.push_back({alu_out, w_flags});
                            void'(exp_q.pop_front());
                        end
                    end
                end
                if (alu_in_valid && alu_in_ready) begin
                    model_op(alu_fcn, alu_in1, alu_in2, alu_sat, r);
                    exp_q.push_back(r);
                end
            end
        end
    end

    // Sole driver of alu_out_ready.
    initial begin
        alu_out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            alu_out_ready = rdy_force ? rdy_val : ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b, input logic s);
        alu_in_valid = 1'b1;
        alu_fcn = f; alu_in1 = a; alu_in2 = b; alu_sat = s;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (alu_in_ready) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        check("issue_timeout", 64'd1, 64'd0);
    endtask

    task automatic idle(input int n);
        alu_in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain();
        alu_in_valid = 1'b0;
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        idle(2);
    endtask

    task automatic chk_log(input string tag, input int idx, input logic [31:0] eo, input logic [4:0] ef);
        if (idx < got_q.size()) check(tag, 64'(got_q[idx]), 64'({eo, ef}));
        else check({tag, "_missing"}, 64'(got_q.size()), 64'(idx + 1));
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            4: return $urandom_range(0, 40);
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int base;
        int unsigned r;
        rst = 1'b1;
        alu_in_valid = 1'b0;
        alu_in1 = '0; alu_in2 = '0; alu_fcn = '0; alu_sat = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b0;
        check("rst_out_valid", 64'(alu_out_valid), 64'd0);
        check("rst_in_ready", 64'(alu_in_ready), 64'd1);
        check("rst_out", 64'(alu_out), 64'd0);
        check("rst_flags", 64'(w_flags), 64'd0);

        // Carry chain
        base = got_q.size();
        issue(5'd4, 32'hFFFF_FFFF, 32'h1, 1'b0);
        issue(5'd6, 32'h0, 32'h0, 1'b0);
        drain();
        chk_log("add_carry", base, 32'h0, 5'b11000);
        chk_log("adc_cin", base + 1, 32'h1, 5'b00000);

        // Signed overflow with and without saturation
        base = got_q.size();
        issue(5'd4, 32'h7FFF_FFFF, 32'h1, 1'b0);
        issue(5'd4, 32'h7FFF_FFFF, 32'h1, 1'b1);
        drain();
        chk_log("add_ovf_wrap", base, 32'h8000_0000, 5'b00110);
        chk_log("add_ovf_sat", base + 1, 32'h7FFF_FFFF, 5'b00010);

        // MAC sequence with an illegal op in the middle
        base = got_q.size();
        issue(5'd13, 32'h0, 32'h0, 1'b0);
        issue(5'd12, 32'd3, 32'hFFFF_FFFC, 1'b0);
        issue(5'd31, 32'h1234, 32'h5678, 1'b0);
        issue(5'd12, 32'd5, 32'd5, 1'b0);
        issue(5'd14, 32'h0, 32'h0, 1'b0);
        drain();
        chk_log("accclr", base, 32'h0, 5'b01000);
        chk_log("mac_neg", base + 1, 32'hFFFF_FFF4, 5'b00100);
        chk_log("illegal", base + 2, 32'h0, 5'b00001);
        chk_log("mac_pos", base + 3, 32'hD, 5'b00000);
        chk_log("accrd", base + 4, 32'hD, 5'b00000);

        // Shift boundaries
        base = got_q.size();
        issue(5'd10, 32'h8000_0000, 32'd40, 1'b0);
        issue(5'd9, 32'h8000_0000, 32'd40, 1'b0);
        issue(5'd8, 32'h1, 32'd31, 1'b0);
        drain();
        chk_log("sar_big", base, 32'hFFFF_FFFF, 5'b00100);
        chk_log("shr_big", base + 1, 32'h0, 5'b01000);
        chk_log("shl_31", base + 2, 32'h8000_0000, 5'b00100);

        // Backpressure: hold output for 3 cycles with a full pipeline
        rdy_val = 1'b0;
        base = got_q.size();
        issue(5'd4, 32'd1, 32'd2, 1'b0);
        issue(5'd3, 32'hF0, 32'hFF, 1'b0);
        check("stall_in_ready", 64'(alu_in_ready), 64'd0);
        check("stall_out_valid", 64'(alu_out_valid), 64'd1);
        alu_fcn = 5'd1; alu_in1 = 32'h100; alu_in2 = 32'h1; alu_sat = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check("stall_hold_ready", 64'(alu_in_ready), 64'd0);
        end
        rdy_val = 1'b1;
        issue(5'd1, 32'h100, 32'h1, 1'b0);
        issue(5'd0, 32'h0, 32'h0, 1'b0);
        drain();
        chk_log("stall_r0", base, 32'h3, 5'b00000);
        chk_log("stall_r1", base + 1, 32'h0F, 5'b00000);
        chk_log("stall_r2", base + 2, 32'h101, 5'b00000);
        chk_log("stall_r3", base + 3, 32'hFFFF_FFFF, 5'b00100);
        check("stall_count", 64'(got_q.size() - base), 64'd4);

        // Reset during a stalled full pipeline with a nonzero accumulator
        issue(5'd12, 32'd7, 32'd9, 1'b0);
        drain();
        rdy_val = 1'b0;
        issue(5'd4, 32'd5, 32'd5, 1'b0);
        issue(5'd5, 32'd3, 32'd9, 1'b0);
        alu_in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        rdy_val = 1'b1;
        check("mrst_out_valid", 64'(alu_out_valid), 64'd0);
        check("mrst_out", 64'(alu_out), 64'd0);
        check("mrst_flags", 64'(w_flags), 64'd0);
        check("mrst_in_ready", 64'(alu_in_ready), 64'd1);
        base = got_q.size();
        issue(5'd14, 32'h0, 32'h0, 1'b1);
        issue(5'd6, 32'h0, 32'h0, 1'b0);
        drain();
        chk_log("mrst_accrd", base, 32'h0, 5'b01000);
        chk_log("mrst_adc", base + 1, 32'h0, 5'b01000);

        // Randomized ops with random output backpressure
        rdy_force = 1'b0;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 17);
            issue((r < 15) ? 5'(r) : 5'($urandom_range(15, 31)),
                  rnd_opnd(), rnd_opnd(), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 2));
        end
        rdy_force = 1'b1;
        rdy_val   = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
